shift_req_stage: RTL and testbench

//  Registered valid/ready request stage directly upstream of the generic left/right shifters.

---
 rtl/shift_req_stage_pkg.sv | 23 ++
 rtl/shift_req_stage_if.sv | 37 +++
 rtl/shift_req_stage_norm.sv | 38 +++
 rtl/shift_req_stage.sv | 127 ++++++++++++
 tb/tb_shift_req_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/shift_req_stage_pkg.sv
// Shared definitions for the shifter request stage.
//   clog2()  : ceiling log2, used to size the shift fields
//   state_e  : occupancy of the 2-entry skid buffer (entries held)
// The request record {sat, left, shift, bits} depends on the data width, so each
// user declares it locally with that field order (sat is the MSB).
package shift_req_stage_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_req_stage_if.sv
// Producer and consumer handshake bundle of the shifter request stage.
//   in_valid/in_ready/in_bits/in_shift/in_left : producer side (shift is 0..2*width-1)
//   out_valid/out_ready/out_bits/out_shift/out_left/out_sat : toward the shifter/consumer
//   acc_cnt : count of accepted input transfers
// Modports: master = environment (producer + consumer), slave = the stage.
interface shift_req_stage_if #(
  parameter int unsigned width = 8,
  parameter int unsigned CNT_W = 16
);
  import shift_req_stage_pkg::*;

  localparam int unsigned ShiftW = clog2(width);

  logic              in_valid;
  logic              in_ready;
  logic [width-1:0]  in_bits;
  logic [ShiftW:0]   in_shift;
  logic              in_left;
  logic              out_valid;
  logic              out_ready;
  logic [width-1:0]  out_bits;
  logic [ShiftW-1:0] out_shift;
  logic              out_left;
  logic              out_sat;
  logic [CNT_W-1:0]  acc_cnt;

  modport master (
    output in_valid, in_bits, in_shift, in_left, out_ready,
    input  in_ready, out_valid, out_bits, out_shift, out_left, out_sat, acc_cnt
  );

  modport slave (
    input  in_valid, in_bits, in_shift, in_left, out_ready,
    output in_ready, out_valid, out_bits, out_shift, out_left, out_sat, acc_cnt
  );

endinterface

// File: rtl/shift_req_stage_norm.sv
// Combinational normaliser for shifter requests.
// An out-of-range shift (>= width) is replaced by a zero word with zero shift so the
// downstream shifter yields 0, and is flagged as saturated.
//   i_bits  : raw data word           o_bits  : normalised data word
//   i_shift : raw shift, clog2(w)+1 b  o_shift : normalised shift, clog2(w) b
//                                      o_sat   : request was out of range
module shift_req_stage_norm
  import shift_req_stage_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0]             i_bits,
  input  logic [clog2(width):0]        i_shift,
  output logic [width-1:0]             o_bits,
  output logic [clog2(width)-1:0]      o_shift,
  output logic                         o_sat
);

  localparam int unsigned ShiftW = clog2(width);
  localparam logic [31:0] WidthWord = width;
  localparam logic [ShiftW:0] WidthVal = WidthWord[ShiftW:0];

  logic w_over;

  assign w_over = (i_shift >= WidthVal);

  always_comb begin
    o_bits  = i_bits;
    o_shift = i_shift[ShiftW-1:0];
    o_sat   = 1'b0;
    if (w_over) begin
      o_bits  = '0;
      o_shift = '0;
      o_sat   = 1'b1;
    end
  end

endmodule

// File: rtl/shift_req_stage.sv
// Registered valid/ready request stage feeding the left/right shifters.
// Normalises each accepted request, holds up to two in a skid buffer (main entry
// visible on out_*, skid entry hidden) and keeps out_* stable until popped.
// Full throughput, one cycle latency, no combinational path from inputs to outputs.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, drops any held requests
//   io_bus : handshake bundle (slave side), see shift_req_stage_if
module shift_req_stage
  import shift_req_stage_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_req_stage_if.slave     io_bus
);

  localparam int unsigned ShiftW = clog2(width);

  typedef struct packed {
    logic              sat;
    logic              left;
    logic [ShiftW-1:0] shift;
    logic [width-1:0]  bits;
  } req_t;

  state_e           r_state;
  state_e           w_state_d;
  req_t             r_main;
  req_t             r_skid;
  req_t             w_main_d;
  req_t             w_skid_d;
  req_t             w_req;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic              w_push;
  logic              w_pop;
  logic [width-1:0]  w_norm_bits;
  logic [ShiftW-1:0] w_norm_shift;
  logic              w_norm_sat;

  shift_req_stage_norm #(
    .width (width)
  ) u_norm (
    .i_bits  (io_bus.in_bits),
    .i_shift (io_bus.in_shift),
    .o_bits  (w_norm_bits),
    .o_shift (w_norm_shift),
    .o_sat   (w_norm_sat)
  );

  always_comb begin
    w_req.sat   = w_norm_sat;
    w_req.left  = io_bus.in_left;
    w_req.shift = w_norm_shift;
    w_req.bits  = w_norm_bits;
  end

  assign w_push = io_bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & io_bus.out_ready;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    unique case (r_state)
      StEmpty: begin
        if (w_push) begin
          w_state_d = StOne;
          w_main_d  = w_req;
        end
      end
      StOne: begin
        if (w_push && w_pop) begin
          w_main_d = w_req;
        end else if (w_push) begin
          w_state_d = StTwo;
          w_skid_d  = w_req;
        end else if (w_pop) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        // in_ready is low here, so only a pop can happen
        if (w_pop) begin
          w_state_d = StOne;
          w_main_d  = r_skid;
        end
      end
      default: begin
        w_state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_main      <= w_main_d;
      r_skid      <= w_skid_d;
      r_in_ready  <= (w_state_d != StTwo);
      r_out_valid <= (w_state_d != StEmpty);
      if (w_push) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_bits  = r_main.bits;
  assign io_bus.out_shift = r_main.shift;
  assign io_bus.out_left  = r_main.left;
  assign io_bus.out_sat   = r_main.sat;
  assign io_bus.acc_cnt   = r_cnt;

endmodule

// File: tb/tb_shift_req_stage.sv
// Self-checking bench for shift_req_stage (width=8, CNT_W=4).
module tb_shift_req_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  shift_req_stage_if #(.width(8), .CNT_W(4)) bus ();

  shift_req_stage #(
    .width (8),
    .CNT_W (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] b;
    logic [3:0] s;
    logic       l;
    logic       r;
    logic       ev;
    logic       er;
    logic [7:0] eb;
    logic [2:0] es;
    logic       el;
    logic       esat;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [3:0] s,
                       input logic l, input logic r);
    bus.in_valid  = v;
    bus.in_bits   = b;
    bus.in_shift  = s;
    bus.in_left   = l;
    bus.out_ready = r;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);

    //            v     bits   shift  l     rdy  | ev    er    ebits  es    el    esat  cnt
    vecs[0]  = '{1'b1, 8'hA5, 4'd3,  1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd3, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b1, 8'h0F, 4'd1,  1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 3'd1, 1'b1, 1'b0, 4'd2};
    vecs[2]  = '{1'b1, 8'h5A, 4'd8,  1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 4'd3};
    vecs[3]  = '{1'b1, 8'hFF, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 4'd4};
    vecs[4]  = '{1'b1, 8'h3C, 4'd7,  1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 3'd7, 1'b0, 1'b0, 4'd5};
    vecs[5]  = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd5};
    vecs[6]  = '{1'b1, 8'h11, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1, 1'b0, 4'd6};
    vecs[7]  = '{1'b1, 8'h22, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 3'd2, 1'b1, 1'b0, 4'd7};
    vecs[8]  = '{1'b1, 8'h33, 4'd5,  1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 3'd2, 1'b1, 1'b0, 4'd7};
    vecs[9]  = '{1'b1, 8'h33, 4'd5,  1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 3'd4, 1'b0, 1'b0, 4'd7};
    vecs[10] = '{1'b1, 8'h33, 4'd5,  1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 3'd5, 1'b1, 1'b0, 4'd8};
    vecs[11] = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 3'd5, 1'b1, 1'b0, 4'd8};
    vecs[12] = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd8};
    vecs[13] = '{1'b1, 8'h80, 4'd9,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1, 1'b1, 4'd9};
    vecs[14] = '{1'b0, 8'h00, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 4'd9};

    // Reset state
    step();
    step();
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_bits",  32'(bus.out_bits),  32'd0);
    check("rst out_shift", 32'(bus.out_shift), 32'd0);
    check("rst out_left",  32'(bus.out_left),  32'd0);
    check("rst out_sat",   32'(bus.out_sat),   32'd0);
    check("rst acc_cnt",   32'(bus.acc_cnt),   32'd0);
    rst = 1'b0;

    // Table: streaming, saturation, backpressure, push+pop in ONE
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].l, vecs[i].r);
      step();
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].er));
      check($sformatf("v%0d acc_cnt", i),   32'(bus.acc_cnt),   32'(vecs[i].ec));
      if (vecs[i].ev) begin
        check($sformatf("v%0d out_bits", i),  32'(bus.out_bits),  32'(vecs[i].eb));
        check($sformatf("v%0d out_shift", i), 32'(bus.out_shift), 32'(vecs[i].es));
        check($sformatf("v%0d out_left", i),  32'(bus.out_left),  32'(vecs[i].el));
        check($sformatf("v%0d out_sat", i),   32'(bus.out_sat),   32'(vecs[i].esat));
      end
    end

    // Counter wrap: fresh reset, 17 pushes streaming through
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    check("wrap start cnt", 32'(bus.acc_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 4'(i % 8), 1'b0, 1'b1);
      step();
      if (i == 15) begin
        check("wrap cnt@16", 32'(bus.acc_cnt), 32'd0);
        check("wrap bits@16", 32'(bus.out_bits), 32'd15);
      end
    end
    check("wrap cnt@17", 32'(bus.acc_cnt), 32'd1);
    check("wrap bits@17", 32'(bus.out_bits), 32'd16);
    check("wrap shift@17", 32'(bus.out_shift), 32'd0);

    // Reset mid-stream from TWO
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    step();
    check("drain valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 8'hAA, 4'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'hBB, 4'd3, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
    check("two in_ready",  32'(bus.in_ready),  32'd0);
    check("two out_valid", 32'(bus.out_valid), 32'd1);
    check("two out_bits",  32'(bus.out_bits),  32'hAA);
    check("two acc_cnt",   32'(bus.acc_cnt),   32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 32'd0);
    check("async rst in_ready",  32'(bus.in_ready),  32'd1);
    check("async rst acc_cnt",   32'(bus.acc_cnt),   32'd0);
    check("async rst out_bits",  32'(bus.out_bits),  32'd0);
    check("async rst out_sat",   32'(bus.out_sat),   32'd0);
    #1;
    rst = 1'b0;
    drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    step();
    check("post rst out_valid", 32'(bus.out_valid), 32'd0);
    check("post rst in_ready",  32'(bus.in_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
